spi_ram_peri_sync: RTL and testbench
====================================

Name: spi_ram_peri_sync

Overview:
Next-generation SPI/QSPI RAM peripheral. Replaces direct spi_clk clocking with oversampling on the system clock.
- Synchronises and edge-detects the SPI pins.
- Decodes 03h/02h/6Bh/32h commands with parametrised address width, RAM depth and fast-read dummy count.
- Provides a registered host-side read/write port into the same byte RAM.
- Sits between the chip pads and on-chip logic that shares the buffer with an external SPI master.

Parameters:
RAM_LEN_BITS, 6, log2 of RAM depth in bytes; SPI/host addresses use low RAM_LEN_BITS bits, upper bits ignored (wrap).
ADDR_BITS, 24, SPI address field length in bits (8..32).
FAST_READ_DELAY, 2, dummy spi_clk rising edges between last address bit and first 6Bh data nibble (>=1).
SYNC_STAGES, 2, synchroniser flops on spi_clk/spi_select/spi_d_in (>=2).

Ports:
clk  in  1  system clock; must be >= 4x spi_clk frequency
rst_n  in  1  reset, asynchronous assert, active-low
spi_clk  in  1  SPI clock from pad, mode 0
spi_select  in  1  chip select, active-low
spi_d_in  in  4  D0..D3 from pads; D0 = MOSI
spi_d_out  out  4  D0..D3 to pads; D1 = MISO in single mode
spi_d_oe  out  4  per-pin output enable
host_addr  in  RAM_LEN_BITS  host byte address
host_we  in  1  host write strobe
host_wdata  in  8  host write data
host_rdata  out  8  data at host_addr, registered, 1-cycle latency
busy  out  1  high while synchronised select is active

Behaviour:
- Reset (rst_n low, async): state IDLE; spi_d_out=0, spi_d_oe=0, host_rdata=0, busy=0, shift/count registers 0. RAM contents not reset.
- All SPI inputs pass through SYNC_STAGES flops. rise/fall = one-clk pulse when synced spi_clk goes 0->1 / 1->0. Sampling on rise; output update on fall.
- Synced select high forces IDLE, spi_d_oe=0, busy=0 on the next clk, from any state. Partially received write byte discarded.
- Select low moves IDLE->CMD. Each rise shifts D0 in, MSB first.
- CMD, after 8 bits:
  - 03h/02h/6Bh/32h -> ADDR.
  - Any other opcode -> IGNORE until deselect; oe stays 0.
- ADDR: ADDR_BITS bits, MSB first. On the last bit:
  - 03h -> READ_S. First byte fetched; spi_d_oe=4'b0010 from the next fall.
  - 6Bh -> DUMMY.
  - 02h -> WRITE_S.
  - 32h -> WRITE_Q.
- DUMMY: counts FAST_READ_DELAY rises, then READ_Q. spi_d_oe=4'b1111 from the next fall.
- READ_S: each fall drives current bit on D1, MSB first; D0/D2/D3 = 0. After bit 0 of a byte, address increments and the next byte is fetched.
- READ_Q: each fall drives one nibble, high first. Address increments after the low nibble.
- WRITE_S: 8 rises (MSB first) assemble a byte. WRITE_Q: 2 rises (high nibble first) assemble a byte. Byte committed to RAM 1 clk after completion; address then increments.
- Address arithmetic is modulo 2^RAM_LEN_BITS (top byte wraps to 0).
- Host port: host_rdata <= RAM[host_addr] every clk. host_we writes host_wdata to RAM[host_addr].
  - Same-cycle collision with an SPI commit to the same address: SPI wins.
  - Host read of an address written in that cycle returns old data.
- Reads fetch RAM at byte boundaries, so a host write lands in an SPI read stream only for bytes not yet fetched.
- Edge pulses arriving while reset is asserted are ignored. Reset mid-transfer aborts the transfer; the next transaction needs a fresh select assertion.

Optional Feature:
- Macro SPI_RAM_STATUS_REG_EN.
- Defined: 8-bit status register (reset 00h; bit0 = write-protect WP, other bits read 0).
  - 05h streams status on D1 repeatedly until deselect.
  - 01h writes the next 8 bits to status; only bit0 stored.
  - With WP=1, 02h/32h still run their state machine but RAM commits are suppressed. Host writes are unaffected.
- Undefined: 05h/01h go to IGNORE like any unknown opcode; no status register exists.

Decomposition:
- Package spi_peri_pkg: opcode constants (CMD_READ=03h, CMD_WRITE=02h, CMD_FAST_READ_Q=6Bh, CMD_WRITE_Q=32h, CMD_RDSR=05h, CMD_WRSR=01h); state enum (IDLE, CMD, ADDR, DUMMY, READ_S, READ_Q, WRITE_S, WRITE_Q, IGNORE).
- Sub-module spi_pin_sync: SYNC_STAGES synchroniser plus rise/fall pulse generation for spi_clk, synced select and synced data.

Test Plan:
- Preload RAM[5]=A5h via host; single read 03h, addr 000005h -> D1 yields 10100101 on 8 falls; oe=0010 after last address bit.
- Write 02h addr 000003h data 3Ch,C3h -> host_rdata at addr 3 = 3Ch, addr 4 = C3h, 1 clk after host_addr applied.
- Quad write 32h addr 3Fh (RAM_LEN_BITS=6) nibbles 1,2,3,4 -> RAM[3Fh]=12h, RAM[00h]=34h (wrap).
- Quad read 6Bh, FAST_READ_DELAY=2 -> oe=0000 during 2 dummy rises, then 1111; nibbles match RAM high/low order.
- Deselect after 5 bits of a write byte -> RAM unchanged, oe=0 and busy=0 within SYNC_STAGES+1 clks. Opcode 9Fh -> oe stays 0000 for the whole transaction.
- SPI commit and host_we to the same address in the same clk -> SPI data retained. With SPI_RAM_STATUS_REG_EN: 01h 01h sets WP, then 02h to addr 0 leaves RAM[0] unchanged and 05h returns 01h.

Source files
------------

// File: rtl/spi_peri_pkg.sv
// spi_peri_pkg: opcodes, FSM state encoding and decode helper shared by the SPI RAM peripheral.
package spi_peri_pkg;
  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam logic [7:0] CMD_WRITE       = 8'h02;
  localparam logic [7:0] CMD_FAST_READ_Q = 8'h6B;
  localparam logic [7:0] CMD_WRITE_Q     = 8'h32;
  localparam logic [7:0] CMD_RDSR        = 8'h05;
  localparam logic [7:0] CMD_WRSR        = 8'h01;
  typedef logic [3:0] state_t;
  localparam state_t IDLE    = 4'd0;
  localparam state_t CMD     = 4'd1;
  localparam state_t ADDR    = 4'd2;
  localparam state_t DUMMY   = 4'd3;
  localparam state_t READ_S  = 4'd4;
  localparam state_t READ_Q  = 4'd5;
  localparam state_t WRITE_S = 4'd6;
  localparam state_t WRITE_Q = 4'd7;
  localparam state_t IGNORE  = 4'd8;
  function automatic logic is_mem_op(input logic [7:0] op);
    return op inside {CMD_READ, CMD_WRITE, CMD_FAST_READ_Q, CMD_WRITE_Q};
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronises the SPI pads into clk and derives spi_clk rise/fall and select-assert pulses.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sclk,
  input  logic       i_sel_n,
  input  logic [3:0] i_d,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_sel_n,
  output logic       o_sel_fall,
  output logic [3:0] o_d
);
  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic r_sclk_q;
  logic r_sel_q;
  logic [5:0] w_top;
  assign w_top = r_sync[SYNC_STAGES-1];
  // select resets to "asserted" so a select already held low at reset release never looks like a new transaction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync   <= '0;
      r_sclk_q <= 1'b0;
      r_sel_q  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], {i_d, i_sel_n, i_sclk}};
      r_sclk_q <= w_top[0];
      r_sel_q  <= w_top[1];
    end
  assign o_rise     = w_top[0] & ~r_sclk_q;
  assign o_fall     = ~w_top[0] & r_sclk_q;
  assign o_sel_n    = w_top[1];
  assign o_sel_fall = ~w_top[1] & r_sel_q;
  assign o_d        = w_top[5:2];
endmodule

// File: rtl/spi_ram_peri_sync.sv
// spi_ram_peri_sync: oversampled SPI/QSPI byte-RAM peripheral with a registered host port.
// Define SPI_RAM_STATUS_REG_EN to add the 05h/01h status register with RAM write-protect.
module spi_ram_peri_sync
  import spi_peri_pkg::*;
#(
  parameter int RAM_LEN_BITS    = 6,
  parameter int ADDR_BITS       = 24,
  parameter int FAST_READ_DELAY = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_clk,
  input  logic                    spi_select,
  input  logic [3:0]              spi_d_in,
  output logic [3:0]              spi_d_out,
  output logic [3:0]              spi_d_oe,
  input  logic [RAM_LEN_BITS-1:0] host_addr,
  input  logic                    host_we,
  input  logic [7:0]              host_wdata,
  output logic [7:0]              host_rdata,
  output logic                    busy
);
  localparam int CNT_W = $clog2(ADDR_BITS + FAST_READ_DELAY + 8);
  logic [7:0] r_ram [2**RAM_LEN_BITS];
  state_t r_state;
  logic [7:0] r_op;
  logic [7:0] r_byte;
  logic [7:0] r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [RAM_LEN_BITS-1:0] r_addr;
  logic r_commit;
  logic r_sr;
  logic [3:0] r_dout;
  logic [3:0] r_oe;
  logic [7:0] r_host_rdata;
  logic w_rise;
  logic w_fall;
  logic w_sel_n;
  logic w_sel_fall;
  logic [3:0] w_d;
  logic [7:0] w_op_nx;
  logic [7:0] w_ser_byte;
  logic [7:0] w_quad_byte;
  logic [7:0] w_status;
  logic [RAM_LEN_BITS-1:0] w_addr_nx;
  logic [RAM_LEN_BITS-1:0] w_addr_inc;
  logic w_wp;
  logic w_rdsr;
  logic w_wrsr;
  logic w_spi_we;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sclk     (spi_clk),
    .i_sel_n    (spi_select),
    .i_d        (spi_d_in),
    .o_rise     (w_rise),
    .o_fall     (w_fall),
    .o_sel_n    (w_sel_n),
    .o_sel_fall (w_sel_fall),
    .o_d        (w_d)
  );

  assign w_op_nx     = {r_op[6:0], w_d[0]};
  assign w_addr_nx   = {r_addr[RAM_LEN_BITS-2:0], w_d[0]};
  assign w_ser_byte  = {r_byte[6:0], w_d[0]};
  assign w_quad_byte = {r_byte[3:0], w_d};
  assign w_addr_inc  = r_addr + 1'b1;
  assign w_status    = {7'd0, w_wp};
  assign w_spi_we    = r_commit & ~r_sr & ~w_wp;

`ifdef SPI_RAM_STATUS_REG_EN
  logic r_wp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wp <= 1'b0;
    else if (r_commit && r_sr) r_wp <= r_wdata[0];
  assign w_wp   = r_wp;
  assign w_rdsr = w_op_nx == CMD_RDSR;
  assign w_wrsr = w_op_nx == CMD_WRSR;
`else
  assign w_wp   = 1'b0;
  assign w_rdsr = 1'b0;
  assign w_wrsr = 1'b0;
`endif

  // r_addr doubles as the address shifter, keeping only the low RAM_LEN_BITS of the SPI address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_byte   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_commit <= 1'b0;
      r_sr     <= 1'b0;
      r_dout   <= '0;
      r_oe     <= '0;
    end else begin
      r_commit <= 1'b0;
      if (r_commit && !r_sr) r_addr <= w_addr_inc;
      if (w_sel_n) begin
        r_state <= IDLE;
        r_oe    <= '0;
        r_dout  <= '0;
      end else case (r_state)
        IDLE: if (w_sel_fall) begin
          r_state <= CMD;
          r_cnt   <= '0;
          r_op    <= '0;
          r_sr    <= 1'b0;
        end
        CMD: if (w_rise) begin
          r_op  <= w_op_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(7)) begin
            r_cnt   <= '0;
            r_sr    <= w_rdsr | w_wrsr;
            r_byte  <= w_status;
            r_state <= is_mem_op(w_op_nx) ? ADDR : w_rdsr ? READ_S : w_wrsr ? WRITE_S : IGNORE;
          end
        end
        ADDR: if (w_rise) begin
          r_addr <= w_addr_nx;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(ADDR_BITS - 1)) begin
            r_cnt   <= '0;
            r_byte  <= r_ram[w_addr_nx];
            r_state <= r_op == CMD_READ ? READ_S : r_op == CMD_FAST_READ_Q ? DUMMY :
                       r_op == CMD_WRITE ? WRITE_S : WRITE_Q;
          end
        end
        DUMMY: if (w_rise) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(FAST_READ_DELAY - 1)) begin
            r_cnt   <= '0;
            r_state <= READ_Q;
          end
        end
        READ_S: if (w_fall) begin
          r_oe   <= 4'b0010;
          r_dout <= {2'b00, r_byte[7], 1'b0};
          r_byte <= {r_byte[6:0], 1'b0};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(7)) begin
            r_cnt  <= '0;
            r_addr <= r_sr ? r_addr : w_addr_inc;
            r_byte <= r_sr ? w_status : r_ram[w_addr_inc];
          end
        end
        READ_Q: if (w_fall) begin
          r_oe   <= 4'b1111;
          r_dout <= r_byte[7:4];
          r_byte <= {r_byte[3:0], 4'h0};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_cnt  <= '0;
            r_addr <= w_addr_inc;
            r_byte <= r_ram[w_addr_inc];
          end
        end
        WRITE_S: if (w_rise) begin
          r_byte <= w_ser_byte;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(7)) begin
            r_cnt    <= '0;
            r_commit <= 1'b1;
            r_wdata  <= w_ser_byte;
          end
        end
        WRITE_Q: if (w_rise) begin
          r_byte <= w_quad_byte;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_cnt    <= '0;
            r_commit <= 1'b1;
            r_wdata  <= w_quad_byte;
          end
        end
        default: ;
      endcase
    end

  // SPI write is issued last so it wins a same-address collision with the host
  always_ff @(posedge clk) begin
    if (host_we) r_ram[host_addr] <= host_wdata;
    if (w_spi_we) r_ram[r_addr] <= r_wdata;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_host_rdata <= '0;
    else r_host_rdata <= r_ram[host_addr];

  assign host_rdata = r_host_rdata;
  assign spi_d_out  = r_dout;
  assign spi_d_oe   = r_oe;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_spi_ram_peri_sync.sv
// tb_spi_ram_peri_sync: directed SPI/QSPI and host-port sequence with a scoreboard of expected bytes.
module tb_spi_ram_peri_sync;
  localparam int HALF = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_select = 1'b1;
  logic [3:0] spi_d_in = '0;
  logic [3:0] spi_d_out;
  logic [3:0] spi_d_oe;
  logic [5:0] host_addr = '0;
  logic host_we = 1'b0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic busy;
  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m [64];
  logic [3:0] q_d;
  logic [3:0] q_oe;
  logic [3:0] oe_acc;

  always #5 clk = ~clk;

  spi_ram_peri_sync #(.RAM_LEN_BITS(6), .ADDR_BITS(24), .FAST_READ_DELAY(2), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .spi_select (spi_select),
    .spi_d_in   (spi_d_in),
    .spi_d_out  (spi_d_out),
    .spi_d_oe   (spi_d_oe),
    .host_addr  (host_addr),
    .host_we    (host_we),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  // mode 0 master: drive while low, sample slave output just before the rise
  task automatic clk_bit(input logic [3:0] d);
    spi_d_in = d;
    #HALF;
    q_d = spi_d_out;
    q_oe = spi_d_oe;
    oe_acc = oe_acc | spi_d_oe;
    spi_clk = 1'b1;
    #HALF;
    spi_clk = 1'b0;
  endtask

  task automatic sel_lo();
    @(negedge clk);
    #2;
    spi_select = 1'b0;
    #HALF;
  endtask

  task automatic sel_hi();
    #HALF;
    spi_select = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_s(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) clk_bit({3'b000, v[i]});
  endtask

  task automatic send_cmd_addr(input logic [7:0] op, input logic [23:0] a);
    send_s(op);
    for (int i = 23; i >= 0; i--) clk_bit({3'b000, a[i]});
  endtask

  task automatic read_s(input string tag);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(4'h0);
      v = {v[6:0], q_d[1]};
    end
    check({tag, "_oe"}, {4'h0, q_oe}, 8'h02);
    pop_chk(tag, v);
  endtask

  task automatic read_q(input string tag);
    logic [7:0] v;
    clk_bit(4'h0);
    v[7:4] = q_d;
    clk_bit(4'h0);
    v[3:0] = q_d;
    check({tag, "_oe"}, {4'h0, q_oe}, 8'h0F);
    pop_chk(tag, v);
  endtask

  task automatic host_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    host_wdata = d;
    host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    m[a] = d;
  endtask

  task automatic host_rd(input logic [5:0] a, input string tag);
    exp_q.push_back(m[a]);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    pop_chk(tag, host_rdata);
  endtask

  initial begin
    oe_acc = '0;
    for (int i = 0; i < 64; i++) m[i] = 8'(i * 37 + 11);
    repeat (3) @(negedge clk);
    check("rst_oe", {4'h0, spi_d_oe}, 8'h00);
    check("rst_dout", {4'h0, spi_d_out}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_rdata", host_rdata, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) host_wr(6'(i), m[i]);
    host_wr(6'd5, 8'hA5);
    host_rd(6'd5, "host_pre5");

    // host write and read of the same address in one cycle returns the old byte
    exp_q.push_back(m[9]);
    @(negedge clk);
    host_addr = 6'd9;
    host_wdata = 8'h77;
    host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    pop_chk("host_rd_old", host_rdata);
    m[9] = 8'h77;
    host_rd(6'd9, "host_rd_new");

    // single read across a byte boundary
    sel_lo();
    send_cmd_addr(8'h03, 24'h000005);
    check("rd_oe_addr", {4'h0, q_oe}, 8'h00);
    check("rd_busy", {7'd0, busy}, 8'h01);
    exp_q.push_back(m[5]);
    exp_q.push_back(m[6]);
    read_s("rd_s_5");
    read_s("rd_s_6");
    sel_hi();
    check("rd_end_oe", {4'h0, spi_d_oe}, 8'h00);
    check("rd_end_busy", {7'd0, busy}, 8'h00);

    // serial write of two bytes
    sel_lo();
    send_cmd_addr(8'h02, 24'h000003);
    send_s(8'h3C);
    send_s(8'hC3);
    sel_hi();
    m[3] = 8'h3C;
    m[4] = 8'hC3;
    host_rd(6'd3, "wr_s_3");
    host_rd(6'd4, "wr_s_4");

    // quad write wrapping from the top byte to 0
    sel_lo();
    send_cmd_addr(8'h32, 24'h00003F);
    clk_bit(4'h1);
    clk_bit(4'h2);
    clk_bit(4'h3);
    clk_bit(4'h4);
    sel_hi();
    m[63] = 8'h12;
    m[0] = 8'h34;
    host_rd(6'd63, "wr_q_3f");
    host_rd(6'd0, "wr_q_00");

    // quad fast read with two dummy clocks, wrapping
    sel_lo();
    send_cmd_addr(8'h6B, 24'h00003F);
    oe_acc = '0;
    clk_bit(4'h0);
    clk_bit(4'h0);
    check("dummy_oe", {4'h0, oe_acc}, 8'h00);
    exp_q.push_back(m[63]);
    exp_q.push_back(m[0]);
    exp_q.push_back(m[1]);
    read_q("rd_q_3f");
    read_q("rd_q_00");
    read_q("rd_q_01");
    sel_hi();

    // deselect part-way through the second write byte
    sel_lo();
    send_cmd_addr(8'h02, 24'h00000A);
    send_s(8'h5E);
    for (int i = 0; i < 5; i++) clk_bit(4'h1);
    #HALF;
    check("desel_busy_pre", {7'd0, busy}, 8'h01);
    spi_select = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("desel_busy", {7'd0, busy}, 8'h00);
    check("desel_oe", {4'h0, spi_d_oe}, 8'h00);
    repeat (4) @(negedge clk);
    m[10] = 8'h5E;
    host_rd(6'd10, "wr_full");
    host_rd(6'd11, "wr_partial");

    // unknown opcode keeps the pins tristated
    sel_lo();
    oe_acc = '0;
    send_s(8'h9F);
    for (int i = 0; i < 16; i++) clk_bit(4'h0);
    check("ign_oe", {4'h0, oe_acc}, 8'h00);
    sel_hi();

    // SPI commit and host write hit the same address on the same clock
    sel_lo();
    send_cmd_addr(8'h02, 24'h000014);
    for (int i = 7; i >= 1; i--) clk_bit({3'b000, 8'h96 >> i & 8'h01 ? 1'b1 : 1'b0});
    spi_d_in = 4'h0;
    #HALF;
    spi_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    host_addr = 6'd20;
    host_wdata = 8'hFF;
    host_we = 1'b1;
    @(posedge clk);
    #1;
    host_we = 1'b0;
    #HALF;
    spi_clk = 1'b0;
    sel_hi();
    m[20] = 8'h96;
    host_rd(6'd20, "collide");

    // reset mid-transfer, then select held low: no new transaction may start
    sel_lo();
    for (int i = 0; i < 4; i++) clk_bit(4'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    oe_acc = '0;
    send_cmd_addr(8'h03, 24'h000005);
    for (int i = 0; i < 8; i++) clk_bit(4'h0);
    check("rst_abort_oe", {4'h0, oe_acc}, 8'h00);
    check("rst_abort_busy", {7'd0, busy}, 8'h00);
    sel_hi();
    host_rd(6'd5, "rst_ram_kept");

`ifdef SPI_RAM_STATUS_REG_EN
    sel_lo();
    send_s(8'h01);
    send_s(8'h01);
    sel_hi();
    sel_lo();
    send_cmd_addr(8'h02, 24'h000000);
    send_s(8'h5A);
    sel_hi();
    host_rd(6'd0, "wp_blocked");
    sel_lo();
    send_s(8'h05);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    read_s("rdsr_0");
    read_s("rdsr_1");
    sel_hi();
    sel_lo();
    send_s(8'h01);
    send_s(8'h00);
    sel_hi();
`else
    sel_lo();
    oe_acc = '0;
    send_s(8'h05);
    for (int i = 0; i < 16; i++) clk_bit(4'h0);
    check("no_sr_oe", {4'h0, oe_acc}, 8'h00);
    sel_hi();
`endif

    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
